// File: rtl/datapath_param.sv
// datapath_param: parametrised LC-3 datapath with a priority bus, contention flag
// and a handshaked memory port that gives up after TIMEOUT request cycles.
module datapath_param #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = '0,
   parameter int               TIMEOUT  = 64
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             GATEPC,
   input  logic             GATEMDR,
   input  logic             GATEALU,
   input  logic             GATEMARMUX,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_PC,
   input  logic             LD_CC,
   input  logic             LD_BEN,
   input  logic             LD_REG,
   input  logic             DRMUX,
   input  logic             SR1MUX,
   input  logic             SR2MUX,
   input  logic             ADDR1MUX,
   input  logic [1:0]       PCMUX,
   input  logic [1:0]       ADDR2MUX,
   input  logic [1:0]       ALUK,
   input  logic             MEM_RD,
   input  logic             MEM_WR,
   input  logic             MEM_ACK,
   input  logic [WIDTH-1:0] MEM_RDATA,
   input  logic             MEM_ERR_CLR,
   output logic             MEM_REQ,
   output logic             MEM_WE,
   output logic [WIDTH-1:0] MEM_ADDR,
   output logic [WIDTH-1:0] MEM_WDATA,
   output logic             MEM_DONE,
   output logic             MEM_ERR,
   output logic             BUS_ERR,
   output logic [WIDTH-1:0] BUS,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] IR,
   output logic [WIDTH-1:0] MAR,
   output logic [WIDTH-1:0] MDR,
   output logic [2:0]       NZP,
   output logic             BEN_OUT
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
   logic [WIDTH-1:0] rf_q [8];
   logic [WIDTH-1:0] rf_d [8];
   logic [2:0]       nzp_q, nzp_d;
   logic             ben_q, ben_d, done_q, done_d, err_q, err_d;
   logic [2:0]       sr1, sr2, dr;
   logic [WIDTH-1:0] sr1_val, sr2_val, off6, off9, off11, imm5;
   logic [WIDTH-1:0] addr1, addr2, adder, alu_b, alu, bus;
   logic             req, rd_ack, timeout;

   always_comb begin
      sr1     = SR1MUX ? ir_q[8:6] : ir_q[11:9];
      sr2     = ir_q[2:0];
      dr      = DRMUX ? 3'd7 : ir_q[11:9];
      sr1_val = rf_q[sr1];
      sr2_val = rf_q[sr2];
      off6    = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
      off9    = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
      off11   = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
      imm5    = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};
      addr1   = ADDR1MUX ? sr1_val : pc_q;
      addr2   = ADDR2MUX == 2'd0 ? '0 : ADDR2MUX == 2'd1 ? off6 : ADDR2MUX == 2'd2 ? off9 : off11;
      adder   = addr1 + addr2;
      alu_b   = SR2MUX ? imm5 : sr2_val;
      alu     = ALUK == 2'd0 ? sr1_val + alu_b :
                ALUK == 2'd1 ? sr1_val & alu_b :
                ALUK == 2'd2 ? ~sr1_val : sr1_val;
      // priority mux stands in for the tri-state bus; contention is only flagged
      bus     = GATEMDR ? mdr_q : GATEPC ? pc_q : GATEMARMUX ? adder : GATEALU ? alu : '0;
   end

   always_comb begin
      req     = state_q != IDLE;
      rd_ack  = state_q == RD_WAIT && MEM_ACK;
      timeout = req && !MEM_ACK && cnt_q == CW'(TIMEOUT - 1);
      state_d = !req ? (MEM_RD ? RD_WAIT : MEM_WR ? WR_WAIT : IDLE) :
                (MEM_ACK || timeout) ? IDLE : state_q;
      cnt_d   = req ? cnt_q + 1'b1 : '0;
      done_d  = req && MEM_ACK;
      err_d   = timeout || (err_q && !MEM_ERR_CLR);
   end

   always_comb begin
      pc_d  = !LD_PC ? pc_q :
              PCMUX == 2'd0 ? pc_q + 1'b1 :
              PCMUX == 2'd1 ? bus :
              PCMUX == 2'd2 ? adder : pc_q;
      ir_d  = LD_IR ? bus : ir_q;
      mar_d = (LD_MAR && !req) ? bus : mar_q;
      mdr_d = rd_ack ? MEM_RDATA : LD_MDR ? bus : mdr_q;
      nzp_d = LD_CC ? {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && bus != '0} : nzp_q;
      ben_d = LD_BEN ? |(nzp_q & ir_q[11:9]) : ben_q;
      for (int i = 0; i < 8; i++)
         rf_d[i] = (LD_REG && dr == 3'(i)) ? bus : rf_q[i];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pc_q    <= PC_RESET;
         ir_q    <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         nzp_q   <= '0;
         ben_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rf_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         nzp_q   <= nzp_d;
         ben_q   <= ben_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rf_q    <= rf_d;
      end
   end

   assign MEM_REQ   = req;
   assign MEM_WE    = state_q == WR_WAIT;
   assign MEM_ADDR  = mar_q;
   assign MEM_WDATA = mdr_q;
   assign MEM_DONE  = done_q;
   assign MEM_ERR   = err_q;
   assign BUS_ERR   = (GATEMDR && (GATEPC || GATEMARMUX || GATEALU)) ||
                      (GATEPC && (GATEMARMUX || GATEALU)) || (GATEMARMUX && GATEALU);
   assign BUS       = bus;
   assign PC        = pc_q;
   assign IR        = ir_q;
   assign MAR       = mar_q;
   assign MDR       = mdr_q;
   assign NZP       = nzp_q;
   assign BEN_OUT   = ben_q;
endmodule

// File: doc/datapath_param.md
# datapath_param

Parametrised LC-3-style datapath, the next generation of the CPU datapath: generic data width, an internal priority bus with contention detection, and a handshaked memory port with a timeout in place of the fixed-latency MIO path. It sits between the control FSM, which drives the gate, load and mux selects, and the memory or IO bridge. It holds PC, IR, MAR, MDR, the 8-entry register file, the condition codes (NZP) and the branch-enable flag (BEN).

## Interface
- WIDTH, 16, datapath width in bits; must be at least 16. IR fields are always taken from IR[15:0] and sign-extended to WIDTH.
- PC_RESET, 0, value loaded into PC by reset.
- TIMEOUT, 64, maximum wait cycles for MEM_ACK; must be at least 2.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- GATEPC, GATEMDR, GATEALU, GATEMARMUX  in  1 each  bus source enables.
- LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG  in  1 each  register load enables.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  in  1 each  LC-3 mux selects. DRMUX=1 selects R7. SR1MUX=1 selects IR[8:6]. SR2MUX=1 selects imm5. ADDR1MUX=1 selects SR1.
- PCMUX, ADDR2MUX, ALUK  in  2 each  PCMUX: 0=PC+1, 1=BUS, 2=adder, 3=hold. ADDR2MUX: 0=0, 1=off6, 2=off9, 3=off11. ALUK: 0=ADD, 1=AND, 2=NOT A, 3=PASS A.
- MEM_RD, MEM_WR  in  1 each  start a read or write transaction; sampled only in IDLE.
- MEM_ACK  in  1  memory completion strobe.
- MEM_RDATA  in  WIDTH  read data; valid while MEM_ACK=1.
- MEM_ERR_CLR  in  1  clears MEM_ERR.
- MEM_REQ  out  1  transaction outstanding.
- MEM_WE  out  1  1 for a write; valid while MEM_REQ=1.
- MEM_ADDR  out  WIDTH  equals MAR.
- MEM_WDATA  out  WIDTH  equals MDR.
- MEM_DONE  out  1  one-cycle pulse after a successful transaction.
- MEM_ERR  out  1  sticky timeout flag.
- BUS_ERR  out  1  combinational: more than one gate asserted.
- BUS  out  WIDTH  internal bus value.
- PC, IR, MAR, MDR  out  WIDTH each  register values.
- NZP  out  3  condition codes.
- BEN_OUT  out  1  registered branch enable.

## Operation
- Bus is a priority mux, not tri-state. Priority is MDR, then PC, then MARMUX, then ALU. With no gate asserted, BUS=0. With two or more gates asserted, BUS_ERR=1 and the highest-priority source drives BUS.
- Adder output = ADDR2 operand + ADDR1 operand, modulo 2^WIDTH. The offsets are sign-extended: off6=IR[5:0], off9=IR[8:0], off11=IR[10:0], imm5=IR[4:0].
- ALU arithmetic is modulo 2^WIDTH; carry is discarded.
- Register file: 8×WIDTH. Reads are combinational (SR1, SR2=IR[2:0]). Writes occur on the edge when LD_REG=1. A read of the register being written returns the old value in that cycle.
- CC update on LD_CC: N=BUS[WIDTH-1]; Z=(BUS==0); P=!N&&!Z.
- BEN update on LD_BEN: BEN=(N&IR[11])|(Z&IR[10])|(P&IR[9]), using the current registered NZP.
- Memory FSM states are IDLE, RD_WAIT and WR_WAIT.
  - IDLE→RD_WAIT on MEM_RD. IDLE→WR_WAIT on MEM_WR. If both are asserted together, the read wins.
  - In either WAIT state: MEM_REQ=1, and MEM_WE=1 only in WR_WAIT. A cycle counter increments each cycle.
  - MEM_ACK while in a WAIT state: go to IDLE and pulse MEM_DONE for 1 cycle. In RD_WAIT, MDR←MEM_RDATA on the same edge.
  - No ACK after TIMEOUT wait cycles: go to IDLE, set MEM_ERR=1, and do not pulse MEM_DONE. MDR is unchanged.
  - MEM_ACK received in IDLE is ignored.
- While MEM_REQ=1, LD_MAR is ignored, and MEM_RD/MEM_WR are ignored.
- While MEM_REQ=1, LD_MDR is honoured except on the edge of a read ACK, where memory data wins.
- MEM_ERR_CLR clears MEM_ERR. A timeout on the same edge wins, so MEM_ERR is set.
- Reset values:
  - PC=PC_RESET.
  - IR, MAR, MDR and all registers are 0.
  - NZP=000, BEN_OUT=0.
  - FSM=IDLE, so MEM_REQ=0, MEM_WE=0, MEM_DONE=0.
  - MEM_ERR=0.
  - Reset in the middle of a transaction aborts it without a MEM_DONE pulse.

## Timing
- All loads take effect on the rising edge where the enable is high. The new value is visible the following cycle.
- Memory latency: MEM_REQ rises in the cycle after MEM_RD/MEM_WR is sampled in IDLE.
- An ACK in the k-th cycle of MEM_REQ gives:
  - MDR updated and MEM_REQ=0 in cycle k+1;
  - MEM_DONE=1 in cycle k+1 only.
- Minimum transaction length is 1 request cycle, with ACK in the first REQ cycle.
- A timeout drops MEM_REQ after exactly TIMEOUT request cycles. MEM_ERR is visible in the next cycle.
- A new MEM_RD is accepted in the same cycle that MEM_DONE is high.
- BUS, BUS_ERR, MEM_ADDR and MEM_WDATA are combinational from the registered state and the control inputs.

## Test plan
- Reset with PC_RESET=16'h3000 → PC=3000, NZP=000, MEM_REQ=0, MEM_ERR=0. Then GATEPC+LD_MAR, PCMUX=0, LD_PC → MAR=3000, PC=3001.
- MAR=0x3001, MEM_RD, ACK on the 3rd REQ cycle with RDATA=0x1263 → MDR=1263, MEM_DONE high for 1 cycle. Then GATEMDR+LD_IR → IR=1263.
- IR=0x1263 (ADD R1,R1,#3) with R1=0x7FFF, GATEALU, LD_REG, LD_CC → R1=8002, NZP=100. Repeat with WIDTH=32 → R1=00008002, NZP=001.
- Write with MDR=0xBEEF and no ACK, TIMEOUT=4 → MEM_REQ=1, MEM_WE=1 for exactly 4 cycles, then MEM_REQ=0, MEM_ERR=1, no MEM_DONE. MEM_ERR_CLR → MEM_ERR=0.
- GATEPC and GATEALU asserted together with PC=0x3005 → BUS_ERR=1, BUS=3005. No gates → BUS=0, and LD_CC gives NZP=010.
- NZP=010, IR[11:9]=010, LD_BEN → BEN_OUT=1. Reset asserted during RD_WAIT with ACK on the same edge → MDR=0, no MEM_DONE.
